// File: rtl/test_package.sv
// Shared s_ing beat type plus the arbiter's source index and FSM state types.
package test_package;
  localparam int NUM         = 6;
  localparam int NUM_REQ_DEF = 4;

  typedef struct packed {
    logic [31:0]    op;
    logic [NUM-1:0] pl;
  } s_ing;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] src_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;
endpackage

// File: rtl/ing_rr_arbiter_rr_pick.sv
// Rotate-priority first-one finder: the first set bit of req at or after ptr, wrapping.
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);
  logic [W:0]   sum_s;
  logic [W-1:0] k_s;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx   = '0;
    sum_s = '0;
    k_s   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum_s = {1'b0, ptr} + (W+1)'(i);
      k_s   = (sum_s >= (W+1)'(N)) ? W'(sum_s - (W+1)'(N)) : W'(sum_s);
      idx   = req[k_s] ? k_s : idx;
    end
  end

  assign found = |req;
endmodule

// File: rtl/ing_rr_arbiter.sv
// Round-robin s_ing arbiter with burst lock and a single registered output stage.
module ing_rr_arbiter
  import test_package::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  localparam int SW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_vld,
  input  s_ing [NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_rdy,
  output logic                 out_vld,
  output s_ing                 out_data,
  output logic                 out_last,
  output logic [SW-1:0]        out_src,
  input  logic                 out_rdy,
  output logic                 busy
);
  arb_state_e    state_r, next_state_s;
  logic [SW-1:0] owner_r, rr_ptr_r, pick_idx_s, next_ptr_s;
  logic [CW-1:0] beat_cnt_r;
  logic          pick_found_s, slot_free_s, accept_s, last_s;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_vld),
    .ptr   (rr_ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // The output slot can take a beat when empty or being drained this cycle.
  assign slot_free_s = !out_vld || out_rdy;
  assign accept_s    = (state_r == LOCK) && req_vld[owner_r] && slot_free_s;
  assign last_s      = req_last[owner_r] || (beat_cnt_r == CW'(MAX_BURST - 1));
  assign next_ptr_s  = (owner_r == SW'(NUM_REQ - 1)) ? '0 : owner_r + SW'(1);
  assign busy        = (state_r == LOCK);

  // Only the current owner ever sees ready.
  always_comb begin
    req_rdy = '0;
    if (state_r == LOCK) begin
      req_rdy[owner_r] = slot_free_s;
    end else begin
      req_rdy = '0;
    end
  end

  // Next-state logic: grant on any request, release on the last accepted beat.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) next_state_s = LOCK;
        else              next_state_s = IDLE;
      end
      LOCK: begin
        if (accept_s && last_s) next_state_s = IDLE;
        else                    next_state_s = LOCK;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Grant owner, round-robin pointer and beat counter.
  always_ff @(posedge clock) begin
    if (rst) begin
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else if ((state_r == IDLE) && pick_found_s) begin
      owner_r    <= pick_idx_s;
      beat_cnt_r <= '0;
    end else if (accept_s) begin
      beat_cnt_r <= beat_cnt_r + CW'(1);
      if (last_s) rr_ptr_r <= next_ptr_s;
    end
  end

  // Output register: a new beat may replace the one draining in the same cycle.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_src  <= '0;
    end else if (accept_s) begin
      out_vld  <= 1'b1;
      out_data <= req_data[owner_r];
      out_last <= last_s;
      out_src  <= owner_r;
    end else if (out_vld && out_rdy) begin
      out_vld  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ing_rr_arbiter.sv
// Directed and random checks of ing_rr_arbiter against a cycle-level behavioural model.
module tb_ing_rr_arbiter;
  import test_package::*;

  localparam int N    = 4;
  localparam int MAXB = 8;

  logic           clock = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld, req_last, req_rdy;
  s_ing [N-1:0]   req_data;
  logic           out_vld, out_last, out_rdy, busy;
  s_ing           out_data;
  logic [1:0]     out_src;

  int checks = 0;
  int failures = 0;

  // model state
  bit   m_busy, m_ovld, m_olast;
  int   m_owner, m_ptr, m_cnt, m_osrc;
  s_ing m_odata;

  // stimulus counters and delivered-beat log
  int          seq [N];
  logic [31:0] base [N];
  int          dsrc [$];
  logic [31:0] dop [$];
  logic        dlast [$];

  ing_rr_arbiter #(.NUM_REQ(N), .MAX_BURST(MAXB)) dut (
    .clock(clock), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_last(req_last), .req_rdy(req_rdy), .out_vld(out_vld),
    .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_rdy(out_rdy), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit rdy, acc, lst, found;
    int k;
    if (rst) begin
      m_busy = 0; m_ovld = 0; m_olast = 0;
      m_owner = 0; m_ptr = 0; m_cnt = 0; m_osrc = 0; m_odata = '0;
    end else if (!m_busy) begin
      if (m_ovld && out_rdy) m_ovld = 0;
      found = 0;
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && req_vld[k]) begin
          found = 1; m_owner = k; m_busy = 1; m_cnt = 0;
        end
      end
    end else begin
      rdy = !m_ovld || out_rdy;
      acc = req_vld[m_owner] && rdy;
      if (m_ovld && out_rdy) m_ovld = 0;
      if (acc) begin
        lst = req_last[m_owner] || (m_cnt + 1 == MAXB);
        m_odata = req_data[m_owner];
        m_osrc = m_owner;
        m_ovld = 1;
        m_olast = lst;
        m_cnt++;
        seq[m_owner]++;
        if (lst) begin
          m_busy = 0;
          m_ptr = (m_owner + 1) % N;
        end
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] erdy;
    #1;
    erdy = '0;
    if (m_busy && (!m_ovld || out_rdy)) erdy[m_owner] = 1'b1;
    check("req_rdy", 64'(req_rdy), 64'(erdy));
    check("busy", 64'(busy), 64'(m_busy));
    check("out_vld", 64'(out_vld), 64'(m_ovld));
    check("out_data", 64'(out_data), 64'(m_odata));
    check("out_last", 64'(out_last), 64'(m_olast));
    check("out_src", 64'(out_src), 64'(m_osrc));
    if (out_vld && out_rdy) begin
      dsrc.push_back(int'(out_src));
      dop.push_back(out_data.op);
      dlast.push_back(out_last);
    end
    model_step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic dtick();
    for (int i = 0; i < N; i++) begin
      req_data[i].op = base[i] + 32'(seq[i]);
      req_data[i].pl = 6'(seq[i]);
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_vld = '0;
    tick();
    rst = 1'b0;
    dsrc.delete(); dop.delete(); dlast.delete();
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      base[i] = 32'(i) << 8;
    end
  endtask

  initial begin
    int n2;
    rst = 1'b1; req_vld = 4'hF; req_last = '0; out_rdy = 1'b1; req_data = '0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; base[i] = 32'(i) << 8; end
    m_busy = 0; m_ovld = 0; m_olast = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_osrc = 0;
    m_odata = '0;
    @(posedge clock); @(negedge clock);

    // 1: reset held with all requesters valid
    for (int c = 0; c < 3; c++) tick();

    // 2: fairness, one-beat grants
    rst = 1'b0; req_vld = 4'hF; req_last = 4'hF; out_rdy = 1'b1;
    dsrc.delete(); dop.delete(); dlast.delete();
    for (int c = 0; c < 18; c++) dtick();
    check("t2_count", 64'(dsrc.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < dsrc.size()) check("t2_src", 64'(dsrc[i]), 64'(i % 4));

    // 3: forced release every MAX_BURST beats, req 0 between chunks
    do_reset();
    req_vld = 4'b0101; req_last = 4'b0001; out_rdy = 1'b1;
    for (int c = 0; c < 200 && seq[2] < 20; c++) dtick();
    check("t3_timeout", 64'(seq[2] >= 20), 64'd1);
    req_vld = '0;
    for (int c = 0; c < 4; c++) dtick();
    n2 = 0;
    for (int i = 0; i < dsrc.size(); i++) begin
      if (dsrc[i] == 2) begin
        n2++;
        check("t3_last", 64'(dlast[i]), 64'(n2 % 8 == 0));
        check("t3_op", 64'(dop[i]), 64'(32'h200 + 32'(n2 - 1)));
        if ((n2 == 8 || n2 == 16) && i + 1 < dsrc.size())
          check("t3_between", 64'(dsrc[i+1]), 64'd0);
      end
    end
    check("t3_count", 64'(n2), 64'd20);

    // 4: backpressure mid-burst
    do_reset();
    base[1] = 32'h0000_00A0;
    req_vld = 4'b0010; req_last = '0; out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) dtick();
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) dtick();
    out_rdy = 1'b1;
    for (int c = 0; c < 100 && seq[1] < 12; c++) dtick();
    req_vld = '0;
    for (int c = 0; c < 4; c++) dtick();
    check("t4_count", 64'(dop.size()), 64'd12);
    for (int i = 0; i < dop.size(); i++)
      check("t4_op", 64'(dop[i]), 64'(32'h0000_00A0 + 32'(i)));

    // 5: pointer wrap
    do_reset();
    req_vld = 4'b0100; req_last = 4'hF; out_rdy = 1'b1;
    for (int c = 0; c < 10 && seq[2] < 1; c++) dtick();
    req_vld = 4'b0101;
    for (int c = 0; c < 20 && dsrc.size() < 3; c++) dtick();
    check("t5_count", 64'(dsrc.size() >= 3), 64'd1);
    if (dsrc.size() >= 3) begin
      check("t5_first", 64'(dsrc[0]), 64'd2);
      check("t5_wrap", 64'(dsrc[1]), 64'd0);
      check("t5_next", 64'(dsrc[2]), 64'd2);
    end

    // 6: reset in the middle of a burst
    do_reset();
    req_vld = 4'b0110; req_last = '0; out_rdy = 1'b1;
    for (int c = 0; c < 20 && seq[1] < 3; c++) dtick();
    rst = 1'b1;
    dtick();
    check("t6_vld", 64'(out_vld), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    dsrc.delete();
    for (int c = 0; c < 10 && dsrc.size() < 1; c++) dtick();
    check("t6_count", 64'(dsrc.size() >= 1), 64'd1);
    if (dsrc.size() >= 1) check("t6_src", 64'(dsrc[0]), 64'd1);

    // random traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      req_vld = 4'($urandom);
      req_last = 4'($urandom) & 4'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        req_data[i].op = $urandom;
        req_data[i].pl = 6'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
